// File: rtl/alu_sched_pkg.sv
// Shared definitions for the alu_sched block: opcodes, FSM state encoding
// and the fill value returned by undefined opcodes.
package alu_sched_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_MFLO = 4'b0011;
   localparam logic [3:0] OP_MTLO = 4'b0100;
   localparam logic [3:0] OP_SLTE = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;

   // Undefined opcodes return every result bit set to this value.
   localparam logic UNDEF_FILL = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_RESP = 2'd3
   } state_t;

endpackage

// File: rtl/alu_sched_core.sv
// Combinational single-cycle ALU for every opcode except MUL.
// Comparisons are unsigned; arithmetic wraps at WIDTH bits.
module alu_core
   import alu_sched_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = {WIDTH{UNDEF_FILL}};
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_MFLO: result = lo;
         OP_MTLO: result = a;
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLTE: result = {{(WIDTH-1){1'b0}}, (a <= b)};
         default: result = {WIDTH{UNDEF_FILL}};
      endcase
   end

endmodule

// File: rtl/alu_sched.sv
// Two-port round-robin front end around a shared ALU with a LO register and
// an iterative shift-add multiplier; one operation in flight at a time.
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MUL_STEPS = WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             p0_valid,
   output logic             p0_ready,
   input  logic [3:0]       p0_op,
   input  logic [WIDTH-1:0] p0_a,
   input  logic [WIDTH-1:0] p0_b,
   output logic             p0_rsp_valid,
   input  logic             p0_rsp_ready,
   input  logic             p1_valid,
   output logic             p1_ready,
   input  logic [3:0]       p1_op,
   input  logic [WIDTH-1:0] p1_a,
   input  logic [WIDTH-1:0] p1_b,
   output logic             p1_rsp_valid,
   input  logic             p1_rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   // Handshake: a request is taken in the IDLE cycle where pN_valid and
   // pN_ready are both high; a response is consumed in the RESP cycle where
   // pN_rsp_valid and pN_rsp_ready are both high.

   localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

   state_t           state_q, state_d;
   logic             last_q, gnt_q, grant, accept, rsp_ack, mul_last;
   logic [3:0]       op_q, sel_op;
   logic [WIDTH-1:0] a_q, b_q, sel_a, sel_b, lo_q, res_q;
   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, mul_sum, core_result;
   logic [CNT_W-1:0] step_q;

   assign sel_op   = grant ? p1_op : p0_op;
   assign sel_a    = grant ? p1_a  : p0_a;
   assign sel_b    = grant ? p1_b  : p0_b;
   assign rsp_ack  = gnt_q ? p1_rsp_ready : p0_rsp_ready;
   assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mul_last = (step_q == CNT_W'(MUL_STEPS - 1));

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .lo     (lo_q),
      .result (core_result)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      grant    = 1'b0;
      p0_ready = 1'b0;
      p1_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (p0_valid || p1_valid) begin
               accept   = 1'b1;
               // On a tie the port that did not win last time gets the grant.
               grant    = (p0_valid && p1_valid) ? ~last_q : p1_valid;
               p0_ready = ~grant;
               p1_ready = grant;
               state_d  = (sel_op == OP_MUL) ? ST_MUL : ST_EXEC;
            end
         end
         ST_EXEC: state_d = ST_RESP;
         ST_MUL:  if (mul_last) state_d = ST_RESP;
         ST_RESP: if (rsp_ack) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q   <= 1'b1;
         gnt_q    <= 1'b0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         lo_q     <= '0;
         res_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         step_q   <= '0;
      end else begin
         if (accept) begin
            last_q   <= grant;
            gnt_q    <= grant;
            op_q     <= sel_op;
            a_q      <= sel_a;
            b_q      <= sel_b;
            acc_q    <= '0;
            mcand_q  <= sel_a;
            mplier_q <= sel_b;
            step_q   <= '0;
         end
         if (state_q == ST_EXEC) begin
            res_q <= core_result;
            if (op_q == OP_MTLO) lo_q <= a_q;
         end
         // One multiplier bit per cycle; the final partial sum is the product.
         if (state_q == ST_MUL) begin
            acc_q    <= mul_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            step_q   <= step_q + CNT_W'(1);
            if (mul_last) begin
               res_q <= mul_sum;
               lo_q  <= mul_sum;
            end
         end
      end
   end

   assign p0_rsp_valid = (state_q == ST_RESP) && !gnt_q;
   assign p1_rsp_valid = (state_q == ST_RESP) &&  gnt_q;
   assign rsp_result   = res_q;
   assign rsp_zero     = (res_q == '0);
   assign busy         = (state_q != ST_IDLE);
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_sched.sv
// Randomised and directed checks of alu_sched against a transaction-level
// model of the LO register, round-robin grant and expected latencies.
module tb_alu_sched;

   localparam int W     = 32;
   localparam int STEPS = W;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [1:0]       valid = '0, rsp_rdy = '0;
   logic [1:0]       ready, rsp_v;
   logic [3:0]       op [2];
   logic [W-1:0]     a [2];
   logic [W-1:0]     b [2];
   logic [W-1:0]     rsp_result;
   logic             rsp_zero, busy;
   logic [1:0]       dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [W-1:0] lo_model;
   int           last_model;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_sched #(.WIDTH(W), .MUL_STEPS(STEPS)) dut (
      .clk          (clk),
      .reset        (reset),
      .p0_valid     (valid[0]),
      .p0_ready     (ready[0]),
      .p0_op        (op[0]),
      .p0_a         (a[0]),
      .p0_b         (b[0]),
      .p0_rsp_valid (rsp_v[0]),
      .p0_rsp_ready (rsp_rdy[0]),
      .p1_valid     (valid[1]),
      .p1_ready     (ready[1]),
      .p1_op        (op[1]),
      .p1_a         (a[1]),
      .p1_b         (b[1]),
      .p1_rsp_valid (rsp_v[1]),
      .p1_rsp_ready (rsp_rdy[1]),
      .rsp_result   (rsp_result),
      .rsp_zero     (rsp_zero),
      .busy         (busy),
      .dbg_state    (dbg_state)
   );

   function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] r;
      case (o)
         4'd0: r = x & y;
         4'd1: r = x | y;
         4'd2: r = x + y;
         4'd3: r = lo_model;
         4'd4: r = x;
         4'd5: r = (x <= y) ? 1 : 0;
         4'd6: r = x - y;
         4'd7: r = (x < y) ? 1 : 0;
         4'd8: r = x * y;
         default: r = {W{1'b1}};
      endcase
      return r;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; valid = '0; rsp_rdy = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      lo_model = '0;
      last_model = 1;
   endtask

   // Single-port transaction: request, measured latency, result, hold, consume.
   task automatic do_op(input int p, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int dly);
      int n, m, t, lat;
      logic [W-1:0] exp;
      exp = model(o, x, y);
      lat = (o == 4'd8) ? STEPS + 1 : 2;
      @(posedge clk); #1;
      valid[p] = 1'b1; op[p] = o; a[p] = x; b[p] = y;
      t = 0;
      @(negedge clk);
      while (!ready[p] && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (ready[p] !== 1'b1 || ready[1-p] !== 1'b0) begin
         errors++;
         $display("FAIL accept p%0d op %0h: ready=%b required %b", p, o, ready, 2'(1 << p));
      end
      n = cyc;
      if (o == 4'd4 || o == 4'd8) lo_model = exp;
      last_model = p;
      @(posedge clk); #1;
      valid[p] = 1'b0; op[p] = 4'($urandom); a[p] = $urandom; b[p] = $urandom;
      t = 0;
      @(negedge clk);
      while (!rsp_v[p] && t < 100) begin
         if (ready !== 2'b00) begin
            checks++; errors++;
            $display("FAIL ready_while_busy: ready=%b required 00", ready);
         end
         @(negedge clk); t++;
      end
      m = cyc;
      checks++;
      if (m - n !== lat || rsp_v[p] !== 1'b1) begin
         errors++;
         $display("FAIL latency op %0h: got %0d rsp_valid=%b required %0d", o, m - n, rsp_v[p], lat);
      end
      checks++;
      if (rsp_result !== exp) begin
         errors++;
         $display("FAIL result op %0h a=%h b=%h: got %h required %h", o, x, y, rsp_result, exp);
      end
      checks++;
      if (rsp_zero !== (exp == '0) || rsp_v[1-p] !== 1'b0 || busy !== 1'b1 || ready !== 2'b00) begin
         errors++;
         $display("FAIL resp_flags: zero=%b other_valid=%b busy=%b ready=%b required %b 0 1 00",
                  rsp_zero, rsp_v[1-p], busy, ready, (exp == '0));
      end
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_v[p] !== 1'b1 || rsp_result !== exp) begin
            errors++;
            $display("FAIL resp_hold: valid=%b result=%h required 1 %h", rsp_v[p], rsp_result, exp);
         end
      end
      @(posedge clk); #1 rsp_rdy[p] = 1'b1;
      @(posedge clk); #1 rsp_rdy[p] = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_v !== 2'b00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL after_consume: rsp_valid=%b busy=%b required 00 0", rsp_v, busy);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (ready !== 2'b00 || rsp_v !== 2'b00 || busy !== 1'b0 || rsp_result !== '0 || rsp_zero !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: ready=%b rsp_valid=%b busy=%b result=%h zero=%b required 00 00 0 0 1",
                  ready, rsp_v, busy, rsp_result, rsp_zero);
      end
   endtask

   task automatic test_add();
      do_op(0, 4'd2, 5, 7, 0);
   endtask

   task automatic test_round_robin();
      int g, t, n;
      do_reset();
      @(posedge clk); #1;
      rsp_rdy = 2'b11;
      for (int p = 0; p < 2; p++) begin op[p] = 4'd6; a[p] = 3; b[p] = 3; end
      valid = 2'b11;
      for (int k = 0; k < 3; k++) begin
         t = 0;
         @(negedge clk);
         while (ready == 2'b00 && t < 50) begin @(negedge clk); t++; end
         g = (last_model == 1) ? 0 : 1;
         checks++;
         if (ready !== 2'(1 << g)) begin
            errors++;
            $display("FAIL rr_grant %0d: ready=%b required %b", k, ready, 2'(1 << g));
         end
         last_model = g;
         n = cyc;
         t = 0;
         @(negedge clk);
         while (!rsp_v[g] && t < 50) begin @(negedge clk); t++; end
         checks++;
         if (cyc - n !== 2 || rsp_result !== '0 || rsp_zero !== 1'b1 || rsp_v[1-g] !== 1'b0 || ready !== 2'b00) begin
            errors++;
            $display("FAIL rr_resp %0d: lat=%0d result=%h zero=%b other=%b ready=%b required 2 0 1 0 00",
                     k, cyc - n, rsp_result, rsp_zero, rsp_v[1-g], ready);
         end
      end
      @(posedge clk); #1;
      valid = 2'b00; rsp_rdy = 2'b00;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ready !== 2'b00) begin
         errors++;
         $display("FAIL rr_idle: busy=%b ready=%b required 0 00", busy, ready);
      end
   endtask

   task automatic test_lo();
      do_op(1, 4'd4, 32'hDEADBEEF, $urandom, 1);
      do_op(0, 4'd3, $urandom, $urandom, 0);
   endtask

   task automatic test_mul();
      do_op(0, 4'd8, 32'hFFFFFFFF, 3, 0);
      do_op(0, 4'd3, 0, 0, 2);
   endtask

   task automatic test_compare_undef();
      do_op(0, 4'd7, 32'hFFFFFFFF, 1, 0);
      do_op(0, 4'd5, 9, 9, 0);
      do_op(0, 4'd15, $urandom, $urandom, 0);
   endtask

   task automatic test_reset_mid_mul();
      int n, t, seen;
      @(posedge clk); #1;
      valid[0] = 1'b1; op[0] = 4'd8; a[0] = $urandom; b[0] = $urandom;
      t = 0;
      @(negedge clk);
      while (!ready[0] && t < 50) begin @(negedge clk); t++; end
      n = cyc;
      @(posedge clk); #1 valid[0] = 1'b0;
      while (cyc < n + 10) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      lo_model = '0;
      last_model = 1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy: busy=%b required 0", busy);
      end
      seen = 0;
      for (int i = 0; i < STEPS + 8; i++) begin
         if (rsp_v !== 2'b00) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_no_rsp: rsp_valid seen %0d cycles required 0", seen);
      end
      do_op(0, 4'd3, $urandom, $urandom, 0);
   endtask

   task automatic test_random();
      int p, d;
      logic [3:0] o;
      logic [W-1:0] x, y;
      for (int k = 0; k < 30; k++) begin
         p = $urandom_range(0, 1);
         o = 4'($urandom_range(0, 15));
         x = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
         y = ($urandom_range(0, 3) == 0) ? x : W'($urandom);
         d = $urandom_range(0, 3);
         do_op(p, o, x, y, d);
      end
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin op[p] = '0; a[p] = '0; b[p] = '0; end
      lo_model = '0;
      last_model = 1;
      test_reset();
      test_add();
      test_round_robin();
      test_lo();
      test_mul();
      test_compare_undef();
      test_reset_mid_mul();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
